// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared RISC-V decode definitions used by the pipelined ID stage:
//   - base opcode values (instr[6:0])
//   - ALU operation class encodings carried to EX on alu_op
//   - immediate format selector consumed by riscv_imm_gen
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

endpackage

// File: rtl/riscv_imm_gen.sv
// ---------------------------------------------------------------------------
// riscv_imm_gen
// Combinational immediate generator. Reassembles the scattered immediate
// bits of a 32-bit RISC-V instruction for the selected format and
// sign-extends the result (sign bit instr[31]) to XLEN.
// Ports:
//   instr - 32-bit instruction word
//   fmt   - immediate format (IMM_NONE yields zero)
//   imm   - XLEN-bit sign-extended immediate
// ---------------------------------------------------------------------------
module riscv_imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    // Every format is first built as a 32-bit signed value; widening to
    // XLEN afterwards gives RV64 the same sign extension as RV32.
    always_comb begin
        imm32 = '0;
        case (fmt)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7],
                              instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                              instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_stage_pipe
// Pipelined instruction decode stage with a registered ID/EX output slot.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   in_valid/in_ready             - IF -> ID handshake
//   in_instr, in_pc               - instruction word and its PC
//   flush                         - EX redirect: empties the slot, blocks input
//   out_valid/out_ready           - ID -> EX handshake
//   out_pc, out_imm               - registered PC and sign-extended immediate
//   out_rs1/out_rs2/out_rd        - register indices
//   out_opcode/funct3/funct7      - raw instruction fields
//   out_branch ... out_reg_write  - control bits
//   out_alu_op                    - ALU operation class
//   out_illegal                   - unrecognised opcode
// A load in the slot whose rd feeds the incoming instruction holds that
// instruction back for one cycle, which drains the slot as a bubble.
// ---------------------------------------------------------------------------
module id_stage_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int INST_BITWIDTH    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [INST_BITWIDTH-1:0]    in_instr,
    input  logic [XLEN-1:0]             in_pc,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [XLEN-1:0]             out_pc,
    output logic [XLEN-1:0]             out_imm,
    output logic [REG_NUM_BITWIDTH-1:0] out_rs1,
    output logic [REG_NUM_BITWIDTH-1:0] out_rs2,
    output logic [REG_NUM_BITWIDTH-1:0] out_rd,
    output logic [6:0]                  out_opcode,
    output logic [2:0]                  out_funct3,
    output logic [6:0]                  out_funct7,
    output logic                        out_branch,
    output logic                        out_jump,
    output logic                        out_mem_read,
    output logic                        out_mem_to_reg,
    output logic                        out_mem_write,
    output logic                        out_alu_src,
    output logic                        out_reg_write,
    output logic [1:0]                  out_alu_op,
    output logic                        out_illegal
);

    logic [6:0]                  opcode;
    logic [REG_NUM_BITWIDTH-1:0] rs1, rs2, rd;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[7  +: REG_NUM_BITWIDTH];
    assign rs1    = in_instr[15 +: REG_NUM_BITWIDTH];
    assign rs2    = in_instr[20 +: REG_NUM_BITWIDTH];

    logic       dec_branch, dec_jump, dec_mem_read, dec_mem_to_reg;
    logic       dec_mem_write, dec_alu_src, dec_writes, dec_illegal;
    logic [1:0] dec_alu_op;
    logic       uses_rs1, uses_rs2;
    imm_fmt_e   imm_fmt;
    logic [XLEN-1:0] dec_imm;

    // Control decode per opcode class; anything unrecognised is flagged
    // illegal with every control bit left inactive.
    always_comb begin
        dec_branch     = 1'b0;
        dec_jump       = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_mem_write  = 1'b0;
        dec_alu_src    = 1'b0;
        dec_writes     = 1'b0;
        dec_illegal    = 1'b0;
        dec_alu_op     = ALU_OP_ADD;
        uses_rs1       = 1'b0;
        uses_rs2       = 1'b0;
        imm_fmt        = IMM_NONE;
        case (opcode)
            OP_R: begin
                dec_writes = 1'b1;
                dec_alu_op = ALU_OP_RTYPE;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
            end
            OP_LOAD: begin
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_alu_src    = 1'b1;
                dec_writes     = 1'b1;
                uses_rs1       = 1'b1;
                imm_fmt        = IMM_I;
            end
            OP_IALU: begin
                dec_alu_src = 1'b1;
                dec_writes  = 1'b1;
                dec_alu_op  = ALU_OP_ITYPE;
                uses_rs1    = 1'b1;
                imm_fmt     = IMM_I;
            end
            OP_STORE: begin
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
                imm_fmt       = IMM_S;
            end
            OP_BRANCH: begin
                dec_branch = 1'b1;
                dec_alu_op = ALU_OP_BRANCH;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
                imm_fmt    = IMM_B;
            end
            OP_JAL: begin
                dec_jump   = 1'b1;
                dec_writes = 1'b1;
                imm_fmt    = IMM_J;
            end
            OP_JALR: begin
                dec_jump   = 1'b1;
                dec_writes = 1'b1;
                uses_rs1   = 1'b1;
                imm_fmt    = IMM_I;
            end
            OP_LUI, OP_AUIPC: begin
                dec_alu_src = 1'b1;
                dec_writes  = 1'b1;
                imm_fmt     = IMM_U;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    riscv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr[31:0]),
        .fmt   (imm_fmt),
        .imm   (dec_imm)
    );

    // Load-use check against the load currently sitting in the slot.
    logic hazard, accept;

    assign hazard = out_valid && out_mem_read && (out_rd != '0) &&
                    ((uses_rs1 && (out_rd == rs1)) || (uses_rs2 && (out_rd == rs2)));
    assign in_ready = !rst && !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Slot update: a flush only kills out_valid; draining without a new
    // accept leaves the old fields in place behind a cleared out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_pc         <= '0;
            out_imm        <= '0;
            out_rs1        <= '0;
            out_rs2        <= '0;
            out_rd         <= '0;
            out_opcode     <= '0;
            out_funct3     <= '0;
            out_funct7     <= '0;
            out_branch     <= 1'b0;
            out_jump       <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_to_reg <= 1'b0;
            out_mem_write  <= 1'b0;
            out_alu_src    <= 1'b0;
            out_reg_write  <= 1'b0;
            out_alu_op     <= '0;
            out_illegal    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_pc         <= in_pc;
            out_imm        <= dec_imm;
            out_rs1        <= rs1;
            out_rs2        <= rs2;
            out_rd         <= rd;
            out_opcode     <= opcode;
            out_funct3     <= in_instr[14:12];
            out_funct7     <= in_instr[31:25];
            out_branch     <= dec_branch;
            out_jump       <= dec_jump;
            out_mem_read   <= dec_mem_read;
            out_mem_to_reg <= dec_mem_to_reg;
            out_mem_write  <= dec_mem_write;
            out_alu_src    <= dec_alu_src;
            out_reg_write  <= dec_writes && (rd != '0);
            out_alu_op     <= dec_alu_op;
            out_illegal    <= dec_illegal;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_stage_pipe
// Self-checking bench for id_stage_pipe. A 32-bit instance is the main DUT;
// a 64-bit instance shares its stimulus so RV64 sign extension is covered.
// Directed scenarios use hand-derived constants; the random scenario uses a
// reference model that decodes instructions from the ISA rules and tracks
// the slot as a single valid/contents pair.
// ---------------------------------------------------------------------------
module tb_id_stage_pipe;

    localparam int PW = 106;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic [31:0] in_instr, in_pc;
    logic [63:0] in_pc_64;

    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [6:0]  out_opcode, out_funct7;
    logic [2:0]  out_funct3;
    logic        out_branch, out_jump, out_mem_read, out_mem_to_reg;
    logic        out_mem_write, out_alu_src, out_reg_write, out_illegal;
    logic [1:0]  out_alu_op;

    logic        in_ready_64, out_valid_64;
    logic [63:0] out_pc_64, out_imm_64;
    logic [4:0]  out_rs1_64, out_rs2_64, out_rd_64;
    logic [6:0]  out_opcode_64, out_funct7_64;
    logic [2:0]  out_funct3_64;
    logic        out_branch_64, out_jump_64, out_mem_read_64, out_mem_to_reg_64;
    logic        out_mem_write_64, out_alu_src_64, out_reg_write_64, out_illegal_64;
    logic [1:0]  out_alu_op_64;

    always #5 clk = ~clk;

    assign in_pc_64 = {32'h0, in_pc};

    id_stage_pipe #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_branch(out_branch), .out_jump(out_jump), .out_mem_read(out_mem_read),
        .out_mem_to_reg(out_mem_to_reg), .out_mem_write(out_mem_write),
        .out_alu_src(out_alu_src), .out_reg_write(out_reg_write),
        .out_alu_op(out_alu_op), .out_illegal(out_illegal)
    );

    id_stage_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_64),
        .in_instr(in_instr), .in_pc(in_pc_64), .flush(flush),
        .out_valid(out_valid_64), .out_ready(out_ready), .out_pc(out_pc_64),
        .out_imm(out_imm_64), .out_rs1(out_rs1_64), .out_rs2(out_rs2_64), .out_rd(out_rd_64),
        .out_opcode(out_opcode_64), .out_funct3(out_funct3_64), .out_funct7(out_funct7_64),
        .out_branch(out_branch_64), .out_jump(out_jump_64), .out_mem_read(out_mem_read_64),
        .out_mem_to_reg(out_mem_to_reg_64), .out_mem_write(out_mem_write_64),
        .out_alu_src(out_alu_src_64), .out_reg_write(out_reg_write_64),
        .out_alu_op(out_alu_op_64), .out_illegal(out_illegal_64)
    );

    logic [PW-1:0] act;
    assign act = {out_pc, out_imm, out_rs1, out_rs2, out_rd, out_opcode, out_funct3,
                  out_funct7, out_branch, out_jump, out_mem_read, out_mem_to_reg,
                  out_mem_write, out_alu_src, out_reg_write, out_alu_op, out_illegal};

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        branch, jump, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
        logic [1:0]  alu_op;
        logic        illegal, uses1, uses2;
    } dec_t;

    int   checks = 0;
    int   errors = 0;
    logic m_valid;
    dec_t m;

    // Reference decode written straight from the ISA field definitions.
    function automatic dec_t ref_decode(input logic [31:0] i, input logic [63:0] pc);
        dec_t d;
        d        = '0;
        d.pc     = pc;
        d.opcode = i[6:0];
        d.funct3 = i[14:12];
        d.funct7 = i[31:25];
        d.rd     = i[11:7];
        d.rs1    = i[19:15];
        d.rs2    = i[24:20];
        case (i[6:0])
            7'b0110011: begin d.alu_op = 2'd2; d.reg_write = 1; d.uses1 = 1; d.uses2 = 1; end
            7'b0000011: begin
                d.mem_read = 1; d.mem_to_reg = 1; d.alu_src = 1; d.reg_write = 1; d.uses1 = 1;
                d.imm = 64'($signed(i[31:20]));
            end
            7'b0010011: begin
                d.alu_src = 1; d.reg_write = 1; d.alu_op = 2'd3; d.uses1 = 1;
                d.imm = 64'($signed(i[31:20]));
            end
            7'b0100011: begin
                d.mem_write = 1; d.alu_src = 1; d.uses1 = 1; d.uses2 = 1;
                d.imm = 64'($signed({i[31:25], i[11:7]}));
            end
            7'b1100011: begin
                d.branch = 1; d.alu_op = 2'd1; d.uses1 = 1; d.uses2 = 1;
                d.imm = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            end
            7'b1101111: begin
                d.jump = 1; d.reg_write = 1;
                d.imm = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            end
            7'b1100111: begin
                d.jump = 1; d.reg_write = 1; d.uses1 = 1;
                d.imm = 64'($signed(i[31:20]));
            end
            7'b0110111, 7'b0010111: begin
                d.alu_src = 1; d.reg_write = 1;
                d.imm = 64'($signed({i[31:12], 12'b0}));
            end
            default: d.illegal = 1;
        endcase
        if (d.rd == 5'd0) d.reg_write = 0;
        return d;
    endfunction

    function automatic logic [PW-1:0] pack(input dec_t d);
        return {d.pc[31:0], d.imm[31:0], d.rs1, d.rs2, d.rd, d.opcode, d.funct3, d.funct7,
                d.branch, d.jump, d.mem_read, d.mem_to_reg, d.mem_write, d.alu_src,
                d.reg_write, d.alu_op, d.illegal};
    endfunction

    function automatic logic ref_ready();
        dec_t d;
        logic haz;
        d   = ref_decode(in_instr, in_pc_64);
        haz = m_valid && m.mem_read && (m.rd != 0) &&
              ((d.uses1 && m.rd == d.rs1) || (d.uses2 && m.rd == d.rs2));
        return !rst && !flush && !haz && (!m_valid || out_ready);
    endfunction

    // Advance one clock and update the slot model; returns 1 ns after the edge.
    task automatic clock_edge();
        dec_t d;
        logic acc;
        d   = ref_decode(in_instr, in_pc_64);
        acc = in_valid && ref_ready();
        @(posedge clk);
        if (rst) begin
            m_valid = 0;
            m       = '0;
        end else if (flush) begin
            m_valid = 0;
        end else if (acc) begin
            m_valid = 1;
            m       = d;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 1; in_instr = $urandom; in_pc = $urandom;
        flush = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
        clock_edge();
        clock_edge();
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready);
        end
        checks++;
        if ({out_valid, act} !== '0) begin
            errors++; $display("[TB] FAIL reset_outs: got %h want 0", {out_valid, act});
        end
        checks++;
        if ({out_valid_64, out_imm_64, out_pc_64} !== '0) begin
            errors++; $display("[TB] FAIL reset_outs_64: got %h want 0", {out_valid_64, out_imm_64, out_pc_64});
        end
        rst = 0; flush = 0; in_valid = 0; out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL release_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_addi();
        in_valid = 1; in_instr = 32'hFFF00093; in_pc = 32'h100; out_ready = 1;
        clock_edge();
        in_valid = 0;
        #1;
        checks++;
        if ({out_valid, out_imm, out_rd, out_alu_src, out_reg_write, out_alu_op, out_pc} !==
            {1'b1, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b1, 2'b11, 32'h100}) begin
            errors++;
            $display("[TB] FAIL addi: got v=%b imm=%h rd=%0d src=%b rw=%b op=%b pc=%h want v=1 imm=ffffffff rd=1 src=1 rw=1 op=11 pc=100",
                     out_valid, out_imm, out_rd, out_alu_src, out_reg_write, out_alu_op, out_pc);
        end
        clock_edge();
    endtask

    task automatic test_immediates();
        logic [31:0] ins     [3] = '{32'hFE000EE3, 32'h008000EF, 32'h12345137};
        logic [31:0] exp_imm [3] = '{32'hFFFFFFFC, 32'h00000008, 32'h12345000};
        logic [1:0]  exp_bj  [3] = '{2'b10, 2'b01, 2'b00};
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_instr = ins[i]; in_pc = 32'h200 + 32'(i * 4);
            clock_edge();
            checks++;
            if ({out_valid, out_imm, out_branch, out_jump} !== {1'b1, exp_imm[i], exp_bj[i]}) begin
                errors++;
                $display("[TB] FAIL imm_%0d: got v=%b imm=%h bj=%b%b want v=1 imm=%h bj=%b",
                         i, out_valid, out_imm, out_branch, out_jump, exp_imm[i], exp_bj[i]);
            end
            if (i == 0) begin
                checks++;
                if (out_imm_64 !== 64'hFFFFFFFFFFFFFFFC) begin
                    errors++; $display("[TB] FAIL imm64_beq: got %h want fffffffffffffffc", out_imm_64);
                end
            end
        end
        in_valid = 0;
        clock_edge();
    endtask

    task automatic test_load_use();
        out_ready = 1; in_valid = 1; in_instr = 32'h0000A283; in_pc = 32'h300;
        clock_edge();
        in_instr = 32'h00528333; in_pc = 32'h304;
        #1;
        checks++;
        if ({in_ready, out_valid, out_mem_read, out_rd} !== {1'b0, 1'b1, 1'b1, 5'd5}) begin
            errors++;
            $display("[TB] FAIL load_use_stall: got rdy=%b v=%b mr=%b rd=%0d want rdy=0 v=1 mr=1 rd=5",
                     in_ready, out_valid, out_mem_read, out_rd);
        end
        clock_edge();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("[TB] FAIL load_use_bubble: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        clock_edge();
        in_valid = 0;
        #1;
        checks++;
        if ({out_valid, out_pc, out_rd, out_rs1, out_rs2} !== {1'b1, 32'h304, 5'd6, 5'd5, 5'd5}) begin
            errors++;
            $display("[TB] FAIL load_use_issue: got v=%b pc=%h rd=%0d rs1=%0d rs2=%0d want v=1 pc=304 rd=6 rs1=5 rs2=5",
                     out_valid, out_pc, out_rd, out_rs1, out_rs2);
        end
        clock_edge();
    endtask

    task automatic test_back_to_back();
        out_ready = 1; in_valid = 1; in_instr = 32'h00100093; in_pc = 32'h400;
        clock_edge();
        out_ready = 0; in_instr = 32'h00200113; in_pc = 32'h404;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({in_ready, out_valid, out_pc, out_rd} !== {1'b0, 1'b1, 32'h400, 5'd1}) begin
                errors++;
                $display("[TB] FAIL backpressure_%0d: got rdy=%b v=%b pc=%h rd=%0d want rdy=0 v=1 pc=400 rd=1",
                         c, in_ready, out_valid, out_pc, out_rd);
            end
            clock_edge();
        end
        out_ready = 1;
        clock_edge();
        checks++;
        if ({out_valid, out_pc, out_rd} !== {1'b1, 32'h404, 5'd2}) begin
            errors++; $display("[TB] FAIL drain_first: got v=%b pc=%h rd=%0d want v=1 pc=404 rd=2", out_valid, out_pc, out_rd);
        end
        in_instr = 32'h00300193; in_pc = 32'h408;
        clock_edge();
        in_valid = 0;
        checks++;
        if ({out_valid, out_pc, out_rd} !== {1'b1, 32'h408, 5'd3}) begin
            errors++; $display("[TB] FAIL drain_second: got v=%b pc=%h rd=%0d want v=1 pc=408 rd=3", out_valid, out_pc, out_rd);
        end
        clock_edge();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL drain_empty: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 0; in_valid = 1; in_instr = 32'h00100093; in_pc = 32'h500;
        clock_edge();
        in_pc = 32'h504; flush = 1;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            errors++; $display("[TB] FAIL flush_ready: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
        end
        clock_edge();
        flush = 0; in_valid = 0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_kill: got v=%b want 0", out_valid);
        end
        clock_edge();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_no_accept: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_misc();
        out_ready = 1; in_valid = 1; in_instr = 32'h00100013; in_pc = 32'h600;
        clock_edge();
        checks++;
        if ({out_valid, out_reg_write, out_alu_src, out_alu_op} !== {1'b1, 1'b0, 1'b1, 2'b11}) begin
            errors++;
            $display("[TB] FAIL addi_x0: got v=%b rw=%b src=%b op=%b want v=1 rw=0 src=1 op=11",
                     out_valid, out_reg_write, out_alu_src, out_alu_op);
        end
        in_instr = 32'h0000007F; in_pc = 32'h604;
        clock_edge();
        in_valid = 0;
        checks++;
        if ({out_valid, out_illegal, out_branch, out_jump, out_mem_read, out_mem_to_reg, out_mem_write,
             out_alu_src, out_reg_write, out_alu_op, out_imm} !== {2'b11, 9'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL illegal: got v=%b ill=%b ctrl=%b%b%b%b%b%b%b op=%b imm=%h want v=1 ill=1 ctrl=0 op=00 imm=0",
                     out_valid, out_illegal, out_branch, out_jump, out_mem_read, out_mem_to_reg,
                     out_mem_write, out_alu_src, out_reg_write, out_alu_op, out_imm);
        end
        clock_edge();
    endtask

    task automatic test_random();
        logic [6:0]  ops [10] = '{7'b0110011, 7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011,
                                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'h7F};
        logic [31:0] r;
        for (int c = 0; c < 400; c++) begin
            r        = $urandom;
            r[6:0]   = ops[$urandom_range(0, 9)];
            r[11:7]  = 5'($urandom_range(0, 3));
            r[19:15] = 5'($urandom_range(0, 3));
            r[24:20] = 5'($urandom_range(0, 3));
            in_instr  = r;
            in_pc     = $urandom & 32'hFFFFFFFC;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            #1;
            checks++;
            if (in_ready !== ref_ready()) begin
                errors++; $display("[TB] FAIL rand_ready cycle %0d: got %b want %b", c, in_ready, ref_ready());
            end
            clock_edge();
            checks++;
            if (out_valid !== m_valid) begin
                errors++; $display("[TB] FAIL rand_valid cycle %0d: got %b want %b", c, out_valid, m_valid);
            end
            if (m_valid) begin
                checks++;
                if (act !== pack(m)) begin
                    errors++; $display("[TB] FAIL rand_slot cycle %0d: got %h want %h", c, act, pack(m));
                end
                checks++;
                if (out_imm_64 !== m.imm) begin
                    errors++; $display("[TB] FAIL rand_imm64 cycle %0d: got %h want %h", c, out_imm_64, m.imm);
                end
            end
        end
        in_valid = 0; flush = 0; out_ready = 1;
        clock_edge();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_immediates();
        test_load_use();
        test_back_to_back();
        test_flush();
        test_misc();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
